// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
//
// Instruction-sequencing decoder for the VeriRISC CPU. Turns the current
// opcode, the 3-bit phase count and the accumulator-zero flag into the nine
// datapath control strobes. The decode is purely combinational: the strobes
// follow opcode/phase/zero with zero-cycle latency and have no reset value.
//
// Ports:
//   clk     in   1  system clock (kept for interface uniformity, no state here)
//   rst     in   1  asynchronous active-low reset (kept for uniformity, unused)
//   opcode  in   3  opcode of the current instruction
//   phase   in   3  phase of the 8-phase instruction cycle, 0..7
//   zero    in   1  accumulator equals zero
//   sel     out  1  memory address from PC rather than IR
//   rd      out  1  memory drives the data bus
//   ld_ir   out  1  load instruction register
//   inc_pc  out  1  increment program counter
//   halt    out  1  halt the machine
//   ld_pc   out  1  load program counter
//   data_e  out  1  accumulator drives the data bus
//   ld_ac   out  1  load accumulator from the data bus
//   wr      out  1  write the data bus to memory
// -----------------------------------------------------------------------------
module controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [2:0] phase,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Strobe vector order: {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}
  logic [8:0] ctrl_s;
  logic       aluop_s;

  // clk/rst exist only so the port list matches the other sequential blocks;
  // they intentionally have no effect on the decode.
  logic       unused_s;
  assign unused_s = clk ^ rst;

  // ALU-class instructions all read an operand from memory in execute.
  always_comb begin
    aluop_s = 1'b0;
    case (opcode)
      OP_ADD, OP_AND, OP_XOR, OP_LDA: aluop_s = 1'b1;
      default:                        aluop_s = 1'b0;
    endcase
  end

  // Phase/opcode decode of the nine control strobes.
  always_comb begin
    ctrl_s = 9'b000000000;
    case (phase)
      3'd0: ctrl_s = 9'b100000000;
      3'd1: ctrl_s = 9'b110000000;
      3'd2: ctrl_s = 9'b111000000;
      3'd3: ctrl_s = 9'b111000000;
      3'd4: begin
        // PC advances past the fetched instruction; HLT also raises halt here.
        if (opcode == OP_HLT) begin
          ctrl_s = 9'b000110000;
        end else begin
          ctrl_s = 9'b000100000;
        end
      end
      3'd5: begin
        if (aluop_s) begin
          ctrl_s = 9'b010000000;
        end else begin
          ctrl_s = 9'b000000000;
        end
      end
      3'd6: begin
        if (aluop_s) begin
          ctrl_s = 9'b010000000;
        end else begin
          case (opcode)
            // Skip the next instruction by bumping the PC only when acc is zero.
            OP_SKZ: begin
              if (zero) begin
                ctrl_s = 9'b000100000;
              end else begin
                ctrl_s = 9'b000000000;
              end
            end
            OP_JMP:  ctrl_s = 9'b000001000;
            OP_STO:  ctrl_s = 9'b000000100;
            default: ctrl_s = 9'b000000000;
          endcase
        end
      end
      3'd7: begin
        if (aluop_s) begin
          ctrl_s = 9'b010000010;
        end else begin
          case (opcode)
            OP_JMP:  ctrl_s = 9'b000001000;
            OP_STO:  ctrl_s = 9'b000000101;
            default: ctrl_s = 9'b000000000;
          endcase
        end
      end
      default: ctrl_s = 9'b000000000;
    endcase
  end

  assign sel    = ctrl_s[8];
  assign rd     = ctrl_s[7];
  assign ld_ir  = ctrl_s[6];
  assign inc_pc = ctrl_s[5];
  assign halt   = ctrl_s[4];
  assign ld_pc  = ctrl_s[3];
  assign data_e = ctrl_s[2];
  assign ld_ac  = ctrl_s[1];
  assign wr     = ctrl_s[0];

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
//
// Self-checking bench for controller: directed vectors covering every row of
// the decode, a reset-independence sequence, and randomized opcode/phase/zero/
// rst stimulus compared with a rule-based reference model.
// -----------------------------------------------------------------------------
module tb_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic [2:0] phase;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;

  int tests_run_r;
  int tests_failed_r;

  controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .phase  (phase),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr)
  );

  // Free-running clock; edges at multiples of 5, checks land at 1 + 5k.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctrl_vec();
    return {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
  endfunction

  // Reference: each strobe written as a rule over (opcode, phase, zero).
  function automatic logic [8:0] ref_model(input int op, input int ph, input bit z);
    bit alu;
    bit m_sel, m_rd, m_ir, m_inc, m_hlt, m_ldpc, m_de, m_ldac, m_wr;
    alu    = (op >= 2) && (op <= 5);
    m_sel  = (ph <= 3);
    m_rd   = ((ph >= 1) && (ph <= 3)) || (alu && (ph >= 5));
    m_ir   = (ph == 2) || (ph == 3);
    m_inc  = (ph == 4) || ((op == 1) && (ph == 6) && z);
    m_hlt  = (ph == 4) && (op == 0);
    m_ldpc = (op == 7) && (ph >= 6);
    m_de   = (op == 6) && (ph >= 6);
    m_ldac = alu && (ph == 7);
    m_wr   = (op == 6) && (ph == 7);
    return {m_sel, m_rd, m_ir, m_inc, m_hlt, m_ldpc, m_de, m_ldac, m_wr};
  endfunction

  task automatic check_vec(input string tag, input logic [8:0] actual, input logic [8:0] expected);
    tests_run_r++;
    if (actual !== expected) begin
      tests_failed_r++;
      $display("FAIL %s: got %b expected %b", tag, actual, expected);
    end
  endtask

  task automatic apply(input int op, input int ph, input bit z);
    opcode = op[2:0];
    phase  = ph[2:0];
    zero   = z;
    #5;
  endtask

  initial begin
    logic [8:0] fetch_exp [4];
    logic [8:0] exp_v;
    int         op_r;
    int         ph_r;
    bit         z_r;
    tests_run_r    = 0;
    tests_failed_r = 0;
    fetch_exp[0] = 9'b100000000;
    fetch_exp[1] = 9'b110000000;
    fetch_exp[2] = 9'b111000000;
    fetch_exp[3] = 9'b111000000;

    rst    = 1'b0;
    opcode = 3'd0;
    phase  = 3'd0;
    zero   = 1'b0;
    #1;

    // Fetch phases for every opcode and both zero values.
    for (int op = 0; op < 8; op++) begin
      for (int ph = 0; ph < 4; ph++) begin
        apply(op, ph, op[0]);
        check_vec($sformatf("fetch_op%0d_ph%0d", op, ph), ctrl_vec(), fetch_exp[ph]);
      end
      apply(op, 4, 1'b0);
      exp_v = (op == 0) ? 9'b000110000 : 9'b000100000;
      check_vec($sformatf("ph4_op%0d", op), ctrl_vec(), exp_v);
    end

    // HLT execute phases.
    for (int ph = 5; ph < 8; ph++) begin
      apply(0, ph, 1'b1);
      check_vec($sformatf("hlt_ph%0d", ph), ctrl_vec(), 9'b000000000);
    end

    // SKZ.
    apply(1, 5, 1'b0); check_vec("skz_ph5_z0", ctrl_vec(), 9'b000000000);
    apply(1, 6, 1'b0); check_vec("skz_ph6_z0", ctrl_vec(), 9'b000000000);
    apply(1, 6, 1'b1); check_vec("skz_ph6_z1", ctrl_vec(), 9'b000100000);
    apply(1, 7, 1'b1); check_vec("skz_ph7_z1", ctrl_vec(), 9'b000000000);
    apply(1, 5, 1'b1); check_vec("skz_ph5_z1", ctrl_vec(), 9'b000000000);

    // ALU ops.
    for (int op = 2; op < 6; op++) begin
      apply(op, 5, 1'b0); check_vec($sformatf("alu%0d_ph5", op), ctrl_vec(), 9'b010000000);
      apply(op, 6, 1'b1); check_vec($sformatf("alu%0d_ph6", op), ctrl_vec(), 9'b010000000);
      apply(op, 7, 1'b0); check_vec($sformatf("alu%0d_ph7", op), ctrl_vec(), 9'b010000010);
    end

    // STO and JMP.
    apply(6, 5, 1'b0); check_vec("sto_ph5", ctrl_vec(), 9'b000000000);
    apply(6, 6, 1'b1); check_vec("sto_ph6", ctrl_vec(), 9'b000000100);
    apply(6, 7, 1'b0); check_vec("sto_ph7", ctrl_vec(), 9'b000000101);
    apply(7, 5, 1'b0); check_vec("jmp_ph5", ctrl_vec(), 9'b000000000);
    apply(7, 6, 1'b1); check_vec("jmp_ph6", ctrl_vec(), 9'b000001000);
    apply(7, 7, 1'b0); check_vec("jmp_ph7", ctrl_vec(), 9'b000001000);

    // Reset independence: rst toggles while STO phase 7 is held.
    apply(6, 7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rst = ~rst;
      #5;
      check_vec($sformatf("rst_toggle%0d", i), ctrl_vec(), 9'b000000101);
    end
    rst = 1'b0;

    // Randomized stimulus, rst also randomized.
    for (int i = 0; i < 300; i++) begin
      op_r = int'($urandom_range(7, 0));
      ph_r = int'($urandom_range(7, 0));
      z_r  = bit'($urandom_range(1, 0));
      rst  = 1'($urandom_range(1, 0));
      apply(op_r, ph_r, z_r);
      check_vec($sformatf("rand%0d_op%0d_ph%0d_z%0d", i, op_r, ph_r, z_r),
                ctrl_vec(), ref_model(op_r, ph_r, z_r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run_r, tests_failed_r);
    $finish;
  end

endmodule
